// File: rtl/instruction_fetch_ctrl.sv
// instruction_fetch_ctrl: fetch sequencer between instruction memory and decode.
// Owns the program counter, drives a registered memory address, captures the
// returned word with a valid/ready handshake, handles start, backpressure,
// taken branches (redirect + flush) and end-of-program halt.
// Optional build macro FETCH_WRAP_EN: the program loops back to address 0
// instead of draining and halting at the last word.
module instruction_fetch_ctrl #(
    parameter int tam       = 8,
    parameter int MEM_DEPTH = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           outReady,
    input  logic           branchTaken,
    input  logic [tam-1:0] branchTarget,
    input  logic [tam-1:0] instrIn,
    output logic [tam-1:0] addrOut,
    output logic [tam-1:0] instrOut,
    output logic [tam-1:0] pcOut,
    output logic           instrValid,
    output logic           halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam logic [tam-1:0] LAST_ADDR = tam'(MEM_DEPTH - 1);
    localparam logic [tam:0]   DEPTH_EXT = (tam + 1)'(MEM_DEPTH);

    state_t         r_state;
    logic [tam-1:0] r_addr;
    logic [tam-1:0] r_instr;
    logic [tam-1:0] r_pc;
    logic           r_valid;
    logic           r_halted;

    logic           w_load;
    logic           w_tgt_ok;
    logic           w_at_last;
    logic [tam-1:0] w_addr_inc;

    // Load decision, branch range check and next sequential address
    always_comb begin
        w_load     = !r_valid || outReady;
        w_tgt_ok   = {1'b0, branchTarget} < DEPTH_EXT;
        w_at_last  = (r_addr == LAST_ADDR);
        w_addr_inc = r_addr + tam'(1);
    end

    // Fetch state machine with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_instr  <= '0;
            r_pc     <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_addr  <= '0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (branchTaken) begin
                        // Held word is dropped even if decode accepts it this cycle
                        r_valid <= 1'b0;
                        if (w_tgt_ok) begin
                            r_addr  <= branchTarget;
                            r_state <= S_RUN;
                        end else begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                    end else if (r_state == S_DRAIN) begin
                        if (outReady) begin
                            r_valid  <= 1'b0;
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                    end else if (w_load) begin
                        r_instr <= instrIn;
                        r_pc    <= r_addr;
                        r_valid <= 1'b1;
                        if (w_at_last) begin
`ifdef FETCH_WRAP_EN
                            r_addr <= '0;
`else
                            r_state <= S_DRAIN;
`endif
                        end else begin
                            r_addr <= w_addr_inc;
                        end
                    end
                end
                S_HALT: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state  <= S_RUN;
                        r_addr   <= '0;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addrOut    = r_addr;
    assign instrOut   = r_instr;
    assign pcOut      = r_pc;
    assign instrValid = r_valid;
    assign halted     = r_halted;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: directed vectors with literal expectations
// plus a stream-position model checked against the DUT every cycle.
module tb_instruction_fetch_ctrl;

    localparam int DEPTH = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       outReady = 1'b0;
    logic       branchTaken = 1'b0;
    logic [7:0] branchTarget = '0;
    logic [7:0] instrIn;
    logic [7:0] addrOut;
    logic [7:0] instrOut;
    logic [7:0] pcOut;
    logic       instrValid;
    logic       halted;

    logic [7:0] mem [DEPTH];
    initial begin
        mem[0] = 8'd3;  mem[1] = 8'd9;  mem[2] = 8'd6;
        mem[3] = 8'd5;  mem[4] = 8'd15; mem[5] = 8'd10;
    end

    always #5 clk = ~clk;

    // Combinational instruction memory
    assign instrIn = (int'(addrOut) < DEPTH) ? mem[int'(addrOut)] : 8'h00;

    instruction_fetch_ctrl #(.tam(8), .MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .outReady     (outReady),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .instrIn      (instrIn),
        .addrOut      (addrOut),
        .instrOut     (instrOut),
        .pcOut        (pcOut),
        .instrValid   (instrValid),
        .halted       (halted)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position in the instruction stream. m_next is the next word to
    // fetch; m_next == DEPTH means the program is exhausted (last word pending).
    bit         m_init = 0;
    bit         m_run, m_halt, m_valid;
    int         m_next, m_pc;
    logic [7:0] m_word;

    always @(posedge clk) begin
        int nx;
        if (reset) begin
            m_init <= 1; m_run <= 0; m_halt <= 0; m_valid <= 0;
            m_next <= 0; m_pc <= 0; m_word <= '0;
        end else if (m_init) begin
            if (!m_run) begin
                if (start) begin
                    m_run <= 1; m_halt <= 0; m_next <= 0; m_valid <= 0;
                end
            end else if (branchTaken) begin
                m_valid <= 0;
                if (int'(branchTarget) < DEPTH) m_next <= int'(branchTarget);
                else begin m_run <= 0; m_halt <= 1; end
            end else if (m_next >= DEPTH) begin
                if (outReady) begin m_valid <= 0; m_run <= 0; m_halt <= 1; end
            end else if (!m_valid || outReady) begin
                m_word  <= mem[m_next];
                m_pc    <= m_next;
                m_valid <= 1;
                nx = m_next + 1;
`ifdef FETCH_WRAP_EN
                if (nx == DEPTH) nx = 0;
`endif
                m_next <= nx;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            chk("addrOut", addrOut, (m_next >= DEPTH) ? DEPTH - 1 : m_next);
            chk("instrValid", instrValid, m_valid);
            chk("halted", halted, m_halt);
            if (m_valid) begin
                chk("instrOut", instrOut, m_word);
                chk("pcOut", pcOut, m_pc);
            end
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic rdy,
                       input logic br, input logic [7:0] tgt);
        @(negedge clk);
        reset = rst; start = st; outReady = rdy; branchTaken = br; branchTarget = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq [DEPTH];
        logic [7:0] tgts [8];
        seq[0] = 8'd3;  seq[1] = 8'd9;  seq[2] = 8'd6;
        seq[3] = 8'd5;  seq[4] = 8'd15; seq[5] = 8'd10;
        tgts[0] = 8'd4; tgts[1] = 8'd0; tgts[2] = 8'd5; tgts[3] = 8'd6;
        tgts[4] = 8'd2; tgts[5] = 8'd255; tgts[6] = 8'd1; tgts[7] = 8'd7;

        // 1: reset state, then full program at full throughput
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_addr", addrOut, 0);
        chk("rst_instr", instrOut, 0);
        chk("rst_pc", pcOut, 0);
        chk("rst_valid", instrValid, 0);
        chk("rst_halted", halted, 0);
        cyc(0, 1, 1, 0, 0);
        chk("start_valid", instrValid, 0);
        chk("start_addr", addrOut, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk("seq_instr", instrOut, seq[i]);
            chk("seq_pc", pcOut, i);
            chk("seq_valid", instrValid, 1);
        end
        cyc(0, 0, 1, 0, 0);
`ifdef FETCH_WRAP_EN
        chk("wrap_instr", instrOut, 3);
        chk("wrap_pc", pcOut, 0);
        chk("wrap_halted", halted, 0);
`else
        chk("end_valid", instrValid, 0);
        chk("end_halted", halted, 1);
`endif

        // 2: backpressure holds word 9
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("bp_instr", instrOut, 9);
            chk("bp_pc", pcOut, 1);
            chk("bp_addr", addrOut, 2);
        end
        cyc(0, 0, 1, 0, 0);
        chk("bp_rel_instr", instrOut, 6);
        chk("bp_rel_pc", pcOut, 2);

        // 3: branch while 9 valid, flush even with outReady=1
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("pre_br_instr", instrOut, 9);
        cyc(0, 0, 1, 1, 8'd4);
        chk("br_valid", instrValid, 0);
        chk("br_addr", addrOut, 4);
        cyc(0, 0, 1, 0, 0);
        chk("br_instr", instrOut, 15);
        chk("br_pc", pcOut, 4);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'd2);
        chk("br2_valid", instrValid, 0);
        chk("br2_addr", addrOut, 2);
        cyc(0, 0, 1, 0, 0);
        chk("br2_instr", instrOut, 6);

        // 4: out-of-range branch halts; branch ignored in HALT; restart
        cyc(0, 0, 1, 1, 8'd7);
        chk("oor_halted", halted, 1);
        chk("oor_valid", instrValid, 0);
        cyc(0, 0, 1, 1, 8'd1);
        chk("halt_br_halted", halted, 1);
        cyc(0, 1, 1, 0, 0);
        chk("restart_halted", halted, 0);
        chk("restart_addr", addrOut, 0);
        cyc(0, 0, 1, 0, 0);
        chk("restart_instr", instrOut, 3);

        // 5: reset mid-run with valid word, start ignored under reset
        cyc(0, 0, 1, 0, 0);
        chk("mid_valid", instrValid, 1);
        cyc(1, 1, 1, 0, 0);
        chk("midrst_instr", instrOut, 0);
        chk("midrst_valid", instrValid, 0);
        cyc(1, 1, 1, 0, 0);
        chk("midrst_addr", addrOut, 0);
        cyc(0, 0, 1, 0, 0);
        chk("idle_valid", instrValid, 0);

        // Mixed traffic, model-checked every cycle
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 120; i++) begin
            logic br;
            br = (i % 11 == 7);
            cyc(0, (i % 23 == 0), ((i % 3) != 1) || (i % 17 == 0), br, tgts[i % 8]);
        end
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
